// File: rtl/bus_arb_mux.sv
// -----------------------------------------------------------------------------
// bus_arb_mux
// Registered N:1 bus multiplexer with a request arbiter and a valid/ready
// output handshake. The captured source is chosen either directly through an
// encoded select (forced mode) or by arbitrating over per-source requests,
// using fixed priority (RR=0) or round-robin (RR=1).
//
// Ports
//   clk        in   1        system clock, rising edge
//   clr        in   1        asynchronous active-low reset
//   data_in    in   N*WIDTH  source words, source k at [k*WIDTH +: WIDTH]
//   req        in   N        per-source request, level-sensitive
//   force_en   in   1        forced mode: ignore req, select force_sel
//   force_sel  in   SEL_W    encoded source index for forced mode
//   out_ready  in   1        consumer accepts bus_out this cycle
//   out_valid  out  1        bus_out/bus_sel hold a valid word
//   bus_out    out  WIDTH    registered selected word
//   bus_sel    out  SEL_W    index of the word in bus_out
//   grant      out  N        one-hot pulse marking the source captured now
// -----------------------------------------------------------------------------
module bus_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int SEL_W = 5,
    parameter int RR    = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic [N-1:0]         req,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     bus_out,
    output logic [SEL_W-1:0]     bus_sel,
    output logic [N-1:0]         grant
);

    // One extra bit so that N itself is representable for range compares.
    localparam logic [SEL_W:0] NCOUNT = (SEL_W+1)'(N);

    logic                 outValid_q, outValid_d;
    logic [WIDTH-1:0]     busOut_q, busOut_d;
    logic [SEL_W-1:0]     busSel_q, busSel_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;

    logic                 load;
    logic                 capture;
    logic [SEL_W-1:0]     ptrEff;
    logic [2*N-1:0]       reqShift;
    logic [N-1:0]         reqRot;
    logic                 winFound;
    logic [SEL_W-1:0]     offset;
    logic [SEL_W:0]       idxSum;
    logic [SEL_W-1:0]     winIdx;
    logic [SEL_W-1:0]     selIdx;
    logic [WIDTH-1:0]     selWord;
    logic [N-1:0]         grantVec;
    logic [N-1:0]         grantD;

    // Arbiter: rotate the request vector so the search always starts at bit 0,
    // find the lowest set bit, then add the rotation back modulo N. Fixed
    // priority is the same search with the rotation forced to zero.
    always_comb begin
        ptrEff   = (RR != 0) ? ptr_q : '0;
        reqShift = {req, req} >> ptrEff;
        reqRot   = reqShift[N-1:0];
        winFound = 1'b0;
        offset   = '0;
        for (int j = N-1; j >= 0; j--) begin
            if (reqRot[j]) begin
                winFound = 1'b1;
                offset   = SEL_W'(j);
            end
        end
        idxSum = {1'b0, ptrEff} + {1'b0, offset};
        if (idxSum >= NCOUNT) begin
            idxSum = idxSum - NCOUNT;
        end
        winIdx = idxSum[SEL_W-1:0];
    end

    // Word and grant selection are a full decode over the N legal indices, so
    // an out-of-range force_sel matches nothing and yields a zero word and no
    // grant instead of an X from an out-of-bounds part-select.
    always_comb begin
        selIdx   = force_en ? force_sel : winIdx;
        selWord  = '0;
        grantVec = '0;
        for (int k = 0; k < N; k++) begin
            if (selIdx == SEL_W'(k)) begin
                selWord     = data_in[k*WIDTH +: WIDTH];
                grantVec[k] = 1'b1;
            end
        end
    end

    // Next-state for the output register. While HOLD (valid and not ready)
    // nothing moves; otherwise a forced select or an arbitration winner is
    // captured, and an idle cycle just empties the register.
    always_comb begin
        load       = !outValid_q || out_ready;
        capture    = load && (force_en || winFound);
        outValid_d = outValid_q;
        busOut_d   = busOut_q;
        busSel_d   = busSel_q;
        ptr_d      = ptr_q;
        grantD     = '0;
        if (load) begin
            if (capture) begin
                outValid_d = 1'b1;
                busOut_d   = selWord;
                busSel_d   = selIdx;
                grantD     = grantVec;
                if (!force_en && (RR != 0)) begin
                    ptr_d = (winIdx == SEL_W'(N-1)) ? '0 : winIdx + SEL_W'(1);
                end
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            outValid_q <= 1'b0;
            busOut_q   <= '0;
            busSel_q   <= '0;
            ptr_q      <= '0;
        end else begin
            outValid_q <= outValid_d;
            busOut_q   <= busOut_d;
            busSel_q   <= busSel_d;
            ptr_q      <= ptr_d;
        end
    end

    // grant is combinational, so it is masked while reset is held to keep a
    // source from believing it was captured by an edge that does nothing.
    assign grant     = clr ? grantD : '0;
    assign out_valid = outValid_q;
    assign bus_out   = busOut_q;
    assign bus_sel   = busSel_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_arb_mux
// Drives two instances of bus_arb_mux from the same stimulus: instance A is
// 32 sources round-robin, instance B is 20 sources fixed priority. A small
// reference model predicts grants and the next registered outputs; predicted
// outputs go into a scoreboard queue and are compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_bus_arb_mux;

    logic          clk = 1'b0;
    logic          clr;
    logic [31:0]   src [32];
    logic [31:0]   reqV;
    logic          forceEn;
    logic [4:0]    forceSel;
    logic          ready;

    logic [1023:0] aData;
    logic [639:0]  bData;

    logic          aValid, bValid;
    logic [31:0]   aBus, bBus;
    logic [4:0]    aSel, bSel;
    logic [31:0]   aGrant;
    logic [19:0]   bGrant;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int            mN   [2] = '{32, 20};
    int            mRr  [2] = '{1, 0};
    logic          mValid [2];
    logic [31:0]   mBus   [2];
    logic [4:0]    mSel   [2];
    int            mPtr   [2];

    typedef struct {
        int          inst;
        logic        valid;
        logic [31:0] bus;
        logic [4:0]  sel;
    } expT;

    expT sbQ[$];

    always #5 clk = ~clk;

    // Pack the source words onto both instances' flat data buses.
    always_comb begin
        aData = '0;
        bData = '0;
        for (int k = 0; k < 32; k++) begin
            aData[k*32 +: 32] = src[k];
        end
        for (int k = 0; k < 20; k++) begin
            bData[k*32 +: 32] = src[k];
        end
    end

    bus_arb_mux #(.WIDTH(32), .N(32), .SEL_W(5), .RR(1)) dutA (
        .clk       (clk),
        .clr       (clr),
        .data_in   (aData),
        .req       (reqV),
        .force_en  (forceEn),
        .force_sel (forceSel),
        .out_ready (ready),
        .out_valid (aValid),
        .bus_out   (aBus),
        .bus_sel   (aSel),
        .grant     (aGrant)
    );

    bus_arb_mux #(.WIDTH(32), .N(20), .SEL_W(5), .RR(0)) dutB (
        .clk       (clk),
        .clr       (clr),
        .data_in   (bData),
        .req       (reqV[19:0]),
        .force_en  (forceEn),
        .force_sel (forceSel),
        .out_ready (ready),
        .out_valid (bValid),
        .bus_out   (bBus),
        .bus_sel   (bSel),
        .grant     (bGrant)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Predict this cycle's grant and push the outputs expected after the edge.
    task automatic modelCycle(input int inst, output logic [31:0] g);
        int   n;
        logic load;
        logic found;
        int   w;
        int   idx;
        expT  e;
        n = mN[inst];
        g = '0;
        load = !mValid[inst] || ready;
        if (load) begin
            if (forceEn) begin
                mValid[inst] = 1'b1;
                mSel[inst]   = forceSel;
                if (int'(forceSel) < n) begin
                    g[forceSel] = 1'b1;
                    mBus[inst]  = src[forceSel];
                end else begin
                    mBus[inst]  = '0;
                end
            end else begin
                found = 1'b0;
                w = 0;
                for (int i = 0; i < n; i++) begin
                    idx = (mRr[inst] != 0) ? (mPtr[inst] + i) % n : i;
                    if (!found && reqV[idx]) begin
                        found = 1'b1;
                        w = idx;
                    end
                end
                if (found) begin
                    g[w]         = 1'b1;
                    mValid[inst] = 1'b1;
                    mBus[inst]   = src[w];
                    mSel[inst]   = 5'(w);
                    if (mRr[inst] != 0) begin
                        mPtr[inst] = (w + 1) % n;
                    end
                end else begin
                    mValid[inst] = 1'b0;
                end
            end
        end
        e.inst  = inst;
        e.valid = mValid[inst];
        e.bus   = mBus[inst];
        e.sel   = mSel[inst];
        sbQ.push_back(e);
    endtask

    // One clock of stimulus: called just after a falling edge, checks grants
    // before the rising edge and the scoreboard just after it.
    task automatic applyStimulus(input logic [31:0] r, input logic fe,
                                 input logic [4:0] fs, input logic rdy);
        logic [31:0] gA, gB;
        expT e;
        reqV     = r;
        forceEn  = fe;
        forceSel = fs;
        ready    = rdy;
        #1;
        modelCycle(0, gA);
        modelCycle(1, gB);
        checkOutput("grantA", 64'(aGrant), 64'(gA));
        checkOutput("grantB", 64'(bGrant), 64'(gB[19:0]));
        @(posedge clk);
        #1;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.inst == 0) begin
                checkOutput("validA", 64'(aValid), 64'(e.valid));
                checkOutput("busA",   64'(aBus),   64'(e.bus));
                checkOutput("selA",   64'(aSel),   64'(e.sel));
            end else begin
                checkOutput("validB", 64'(bValid), 64'(e.valid));
                checkOutput("busB",   64'(bBus),   64'(e.bus));
                checkOutput("selB",   64'(bSel),   64'(e.sel));
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge, and no
    // grant may appear while reset is held even with requests pending.
    task automatic doReset();
        clr = 1'b0;
        #1;
        checkOutput("rstValidA", 64'(aValid), 64'd0);
        checkOutput("rstBusA",   64'(aBus),   64'd0);
        checkOutput("rstSelA",   64'(aSel),   64'd0);
        checkOutput("rstGrantA", 64'(aGrant), 64'd0);
        checkOutput("rstValidB", 64'(bValid), 64'd0);
        checkOutput("rstBusB",   64'(bBus),   64'd0);
        checkOutput("rstGrantB", 64'(bGrant), 64'd0);
        for (int i = 0; i < 2; i++) begin
            mValid[i] = 1'b0;
            mBus[i]   = '0;
            mSel[i]   = '0;
            mPtr[i]   = 0;
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        clr      = 1'b0;
        reqV     = 32'h0000_0114;
        forceEn  = 1'b0;
        forceSel = '0;
        ready    = 1'b1;
        for (int k = 0; k < 32; k++) begin
            src[k] = $urandom | 32'h1;
        end
        src[16] = 32'h1234_5678;
        doReset();

        // Forced select in range, then out of range for the 20-source instance.
        applyStimulus(32'h0, 1'b1, 5'd16, 1'b1);
        applyStimulus(32'h0, 1'b1, 5'd31, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 5'd25, 1'b1);

        // Fixed priority keeps granting 2; round-robin walks 2, 4, 8.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0000_0114, 1'b0, 5'd0, 1'b1);
        end

        // Round-robin from a clean pointer, including the 31 -> 0 wrap.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h8000_0011, 1'b0, 5'd0, 1'b1);
        end

        // Back-pressure: load source 3, stall four cycles, then drain to 4.
        src[3] = 32'hDEAD_BEEF;
        applyStimulus(32'h0000_0008, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0000_0030, 1'b0, 5'd0, 1'b0);
        end
        applyStimulus(32'h0000_0030, 1'b0, 5'd0, 1'b1);

        // Reset while holding a word, then idle with no requests.
        applyStimulus(32'h0000_0001, 1'b0, 5'd0, 1'b0);
        doReset();
        applyStimulus(32'h0, 1'b0, 5'd0, 1'b1);
        applyStimulus(32'h0, 1'b0, 5'd0, 1'b1);

        // Mixed random traffic.
        for (int i = 0; i < 80; i++) begin
            src[$urandom_range(0, 31)] = $urandom;
            applyStimulus($urandom & $urandom & $urandom,
                          ($urandom_range(0, 4) == 0),
                          5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
